// File: rtl/lvt_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lvt_write_scheduler
// Purpose  : Init sweep plus round-robin address-conflict arbiter for 8 LVT RAM write ports.
// Revision : 1.0 - initial release
// ============================================================================
module lvt_write_scheduler #(
  parameter int          BLOCKSIZE  = 10,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
  parameter int          CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  req_valid,
  input  logic [8*(BLOCKSIZE+1)-1:0]  req_addr,
  input  logic [8*32-1:0]             req_data,
  output logic [7:0]                  req_ready,
  output logic [7:0]                  w_enb,
  output logic [8*(BLOCKSIZE+1)-1:0]  w_addr,
  output logic [8*32-1:0]             w_din,
  output logic                        init_done,
  output logic [CNT_W-1:0]            collision_cnt
);

  localparam int c_aw = BLOCKSIZE + 1;
  localparam int c_sw = c_aw - 3;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_sw-1:0]   r_sweep_ptr;
  logic [2:0]        r_rr_ptr;
  logic [7:0]        w_win;
  logic [7:0]        w_lead;
  logic [2:0]        w_hi_lead;
  logic              w_stall;
  logic              w_last_group;

  assign w_last_group = (r_sweep_ptr == {c_sw{1'b1}});

  // A request loses only to a same-address request closer to rr_ptr (cyclic distance).
  always_comb begin
    w_win  = req_valid;
    w_lead = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (i != j && req_valid[i] && req_valid[j] &&
            req_addr[i*c_aw +: c_aw] == req_addr[j*c_aw +: c_aw]) begin
          if ((3'(j) - r_rr_ptr) < (3'(i) - r_rr_ptr)) begin
            w_win[i] = 1'b0;
          end else begin
            w_lead[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_hi_lead = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_win[i] && w_lead[i]) begin
        w_hi_lead = 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 8'h00;
    w_stall     = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_last_group) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!rst) begin
          req_ready = w_win;
        end
        w_stall = |(req_valid & ~w_win);
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sweep_ptr   <= '0;
      r_rr_ptr      <= 3'd0;
      w_enb         <= 8'h00;
      w_addr        <= '0;
      w_din         <= '0;
      init_done     <= 1'b0;
      collision_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      w_enb       <= 8'hFF;
      r_sweep_ptr <= r_sweep_ptr + c_sw'(1);
      for (int i = 0; i < 8; i++) begin
        w_addr[i*c_aw +: c_aw] <= {r_sweep_ptr, 3'(i)};
        w_din[i*32 +: 32]      <= INIT_VALUE;
      end
      if (w_last_group) begin
        init_done <= 1'b1;
      end
    end else begin
      w_enb  <= req_ready;
      w_addr <= req_addr;
      w_din  <= req_data;
      if (w_stall) begin
        r_rr_ptr <= w_hi_lead + 3'd1;
        if (collision_cnt != {CNT_W{1'b1}}) begin
          collision_cnt <= collision_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lvt_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvt_write_scheduler
// Purpose  : Directed self-checking bench for lvt_write_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lvt_write_scheduler;

  localparam int c_aw = 11;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         req_valid;
  logic [8*c_aw-1:0]  req_addr;
  logic [255:0]       req_data;
  logic [7:0]         req_ready;
  logic [7:0]         w_enb;
  logic [8*c_aw-1:0]  w_addr;
  logic [255:0]       w_din;
  logic               init_done;
  logic [15:0]        collision_cnt;

  int checks   = 0;
  int failures = 0;

  lvt_write_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .w_enb         (w_enb),
    .w_addr        (w_addr),
    .w_din         (w_din),
    .init_done     (init_done),
    .collision_cnt (collision_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs ncyc sweep cycles, checking each registered group; group 255 raises init_done.
  task automatic sweep(input int ncyc);
    logic [8*c_aw-1:0] exp_a;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) exp_a[i*c_aw +: c_aw] = 11'(k*8 + i);
      check("sweep_enb",  w_enb, 8'hFF);
      check("sweep_addr", w_addr, exp_a);
      check("sweep_din",  w_din, 256'h0);
      check("sweep_rdy",  req_ready, 8'h00);
      check("init_done",  init_done, (k == 255));
    end
  endtask

  initial begin
    logic [8*c_aw-1:0] ea;
    logic [255:0]      ed;
    logic [7:0]        e8;

    // Reset state, with requests pending to show ready is masked
    rst = 1'b1; req_valid = 8'hFF; req_addr = '0; req_data = '0;
    #12;
    check("rst_ready", req_ready, 8'h00);
    check("rst_enb",   w_enb, 8'h00);
    check("rst_addr",  w_addr, '0);
    check("rst_done",  init_done, 1'b0);
    check("rst_cnt",   collision_cnt, 16'h0);
    req_valid = 8'h00;
    @(negedge clk); rst = 1'b0;
    #1 check("pre_sweep_enb", w_enb, 8'h00);
    sweep(256);
    @(posedge clk); #1;
    check("run_idle_enb", w_enb, 8'h00);
    check("run_done",     init_done, 1'b1);
    check("run_cnt0",     collision_cnt, 16'h0);

    // Eight distinct addresses: all granted, issued one cycle later
    for (int i = 0; i < 8; i++) begin
      req_addr[i*c_aw +: c_aw] = 11'h10 + 11'(i);
      req_data[i*32 +: 32]     = 32'hA000_0000 + 32'(i);
    end
    ea = req_addr; ed = req_data;
    req_valid = 8'hFF;
    #1 check("dist_ready", req_ready, 8'hFF);
    @(posedge clk); #1;
    req_valid = 8'h00;
    check("dist_enb",  w_enb, 8'hFF);
    check("dist_addr", w_addr, ea);
    check("dist_din",  w_din, ed);
    check("dist_cnt",  collision_cnt, 16'h0);

    // Requests 2 and 5 collide at 0x40; invalid bits share the address but are ignored
    for (int i = 0; i < 8; i++) req_addr[i*c_aw +: c_aw] = 11'h040;
    req_valid = 8'h24;
    #1 check("coll_ready0", req_ready, 8'h04);
    @(posedge clk); #1;
    check("coll_enb0", w_enb, 8'h04);
    check("coll_cnt",  collision_cnt, 16'd1);
    req_valid = 8'h20;
    #1 check("coll_ready1", req_ready, 8'h20);
    @(posedge clk); #1;
    req_valid = 8'h00;
    check("coll_enb1",  w_enb, 8'h20);
    check("coll_addr5", w_addr[5*c_aw +: c_aw], 11'h040);
    check("coll_cnt1",  collision_cnt, 16'd1);

    // Reset in the middle of a sweep, then a full restart from address 0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sweep(100);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_enb",  w_enb, 8'h00);
    check("mid_rst_done", init_done, 1'b0);
    check("mid_rst_cnt",  collision_cnt, 16'h0);
    check("mid_rst_addr", w_addr, '0);
    @(negedge clk); rst = 1'b0;
    sweep(256);

    // All eight at 0x7FF: one grant per cycle in order 0..7
    for (int i = 0; i < 8; i++) begin
      req_addr[i*c_aw +: c_aw] = 11'h7FF;
      req_data[i*32 +: 32]     = 32'hC0DE_0000 + 32'(i);
    end
    req_valid = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      e8 = 8'h01 << k;
      #1 check("all_ready", req_ready, e8);
      @(posedge clk); #1;
      check("all_enb",  w_enb, e8);
      check("all_addr", w_addr[k*c_aw +: c_aw], 11'h7FF);
      check("all_din",  w_din[k*32 +: 32], 32'hC0DE_0000 + 32'(k));
      req_valid[k] = 1'b0;
    end
    check("all_cnt", collision_cnt, 16'd7);

    // Persistent two-way conflict: alternating grants and counter saturation
    for (int i = 0; i < 8; i++) req_addr[i*c_aw +: c_aw] = 11'h005;
    req_valid = 8'h03;
    for (int n = 1; n <= 65541; n++) begin
      if (n <= 3) begin
        e8 = (n == 2) ? 8'h02 : 8'h01;
        #1 check("sat_ready", req_ready, e8);
      end
      @(posedge clk); #1;
      if (n == 65527) check("sat_pre",  collision_cnt, 16'hFFFE);
      if (n == 65528) check("sat_hit",  collision_cnt, 16'hFFFF);
      if (n == 65541) check("sat_hold", collision_cnt, 16'hFFFF);
    end
    req_valid = 8'h00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
